// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer
//
// Walks a run-time list of address/data slots and hands each enabled slot to
// the bus-timing engine through its addr/data/step handshake, then issues a
// final transfer command. Init mode writes INIT_VALUE to every listed slot,
// regardless of the mask.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   start, init_start      : begin masked write / init sequence (IDLE only;
//                            init_start wins when both are high)
//   abort                  : cancel the run in progress
//   field_mask             : per-slot enable, captured on start
//   field_addr, field_data : flattened slot addresses / data
//                            (slot i is [i*DATA_W +: DATA_W])
//   cmd_addr, cmd_data     : transfer command issued after the slots
//   addr_phase, data_phase,
//   step_done              : handshake from the bus-timing engine
//   bus_byte               : byte presented to the bus engine
//   wr_en                  : write-item enable toward the bus engine
//   busy / term            : running / idle (always complementary)
//   done                   : one-cycle pulse on normal completion
//   timeout_err            : sticky item-timeout flag, cleared by next start
module rtc_write_sequencer #(
    parameter int DATA_W      = 8,
    parameter int N_FIELDS    = 9,
    parameter int INIT_VALUE  = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         init_start,
    input  logic                         abort,
    input  logic [N_FIELDS-1:0]          field_mask,
    input  logic [N_FIELDS*DATA_W-1:0]   field_addr,
    input  logic [N_FIELDS*DATA_W-1:0]   field_data,
    input  logic [DATA_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_data,
    input  logic                         addr_phase,
    input  logic                         data_phase,
    input  logic                         step_done,
    output logic [DATA_W-1:0]            bus_byte,
    output logic                         wr_en,
    output logic                         busy,
    output logic                         term,
    output logic                         done,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(N_FIELDS + 1);
    localparam int TC_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_FIELDS);
    localparam logic [TC_W-1:0]   TC_LAST   = TC_W'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] INIT_BYTE = DATA_W'(INIT_VALUE);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_WRITE, S_GAP, S_CMD, S_FINISH
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic                init_reg, init_next;
    logic [N_FIELDS-1:0] mask_reg, mask_next;
    logic                wrote_reg, wrote_next;
    logic [TC_W-1:0]     tcnt_reg, tcnt_next;
    logic [DATA_W-1:0]   bus_byte_reg, bus_byte_next;
    logic                wr_en_reg, wr_en_next;
    logic                busy_reg, busy_next;
    logic                term_reg, term_next;
    logic                done_reg, done_next;
    logic                terr_reg, terr_next;

    // Slot tables carry one extra zero entry so that any index value,
    // including the saturated N_FIELDS, selects a defined element.
    logic [DATA_W-1:0] addr_arr [N_FIELDS+1];
    logic [DATA_W-1:0] data_arr [N_FIELDS+1];
    logic [N_FIELDS:0] mask_ext;

    genvar gi;
    generate
        for (gi = 0; gi < N_FIELDS; gi++) begin : g_slot
            assign addr_arr[gi] = field_addr[gi*DATA_W +: DATA_W];
            assign data_arr[gi] = field_data[gi*DATA_W +: DATA_W];
        end
    endgenerate
    assign addr_arr[N_FIELDS] = '0;
    assign data_arr[N_FIELDS] = '0;
    assign mask_ext           = {1'b0, mask_reg};

    // WRITE and CMD share one handshake; only the byte source differs.
    logic [DATA_W-1:0] sel_addr, sel_data;
    logic              step_eff;

    assign sel_addr = (state_reg == S_CMD) ? cmd_addr : addr_arr[idx_reg];
    assign sel_data = (state_reg == S_CMD) ? cmd_data :
                      (init_reg ? INIT_BYTE : data_arr[idx_reg]);
    // A step_done coinciding with a phase is dropped, so it cannot rescue
    // an item from timing out either.
    assign step_eff = step_done & ~addr_phase & ~data_phase;

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        init_next     = init_reg;
        mask_next     = mask_reg;
        wrote_next    = wrote_reg;
        tcnt_next     = tcnt_reg;
        bus_byte_next = bus_byte_reg;
        wr_en_next    = wr_en_reg;
        done_next     = 1'b0;
        terr_next     = terr_reg;

        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            wr_en_next = 1'b0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (init_start) begin
                        state_next = S_SCAN;
                        init_next  = 1'b1;
                        idx_next   = '0;
                        wrote_next = 1'b0;
                        terr_next  = 1'b0;
                    end else if (start) begin
                        state_next = S_SCAN;
                        init_next  = 1'b0;
                        mask_next  = field_mask;
                        idx_next   = '0;
                        wrote_next = 1'b0;
                        terr_next  = 1'b0;
                    end
                end
                S_SCAN: begin
                    if (idx_reg == IDX_LAST) begin
                        if (wrote_reg || init_reg) begin
                            state_next = S_CMD;
                            wr_en_next = 1'b1;
                            tcnt_next  = '0;
                        end else begin
                            state_next = S_FINISH;
                        end
                    end else if (mask_ext[idx_reg] || init_reg) begin
                        state_next = S_WRITE;
                        wr_en_next = 1'b1;
                        tcnt_next  = '0;
                        wrote_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
                S_WRITE, S_CMD: begin
                    tcnt_next = tcnt_reg + TC_W'(1);
                    if ((tcnt_reg == TC_LAST) && !step_eff) begin
                        terr_next  = 1'b1;
                        wr_en_next = 1'b0;
                        state_next = S_IDLE;
                    end else if (addr_phase) begin
                        bus_byte_next = sel_addr;
                    end else if (data_phase) begin
                        bus_byte_next = sel_data;
                    end else if (step_done) begin
                        wr_en_next = 1'b0;
                        if (state_reg == S_CMD) begin
                            state_next = S_FINISH;
                        end else begin
                            state_next = S_GAP;
                            if (idx_reg != IDX_LAST) begin
                                idx_next = idx_reg + IDX_W'(1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    state_next = S_SCAN;
                end
                S_FINISH: begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        // busy/term are registered copies of "next state is not IDLE".
        busy_next = (state_next != S_IDLE);
        term_next = ~busy_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            init_reg     <= 1'b0;
            mask_reg     <= '0;
            wrote_reg    <= 1'b0;
            tcnt_reg     <= '0;
            bus_byte_reg <= '0;
            wr_en_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            term_reg     <= 1'b1;
            done_reg     <= 1'b0;
            terr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            init_reg     <= init_next;
            mask_reg     <= mask_next;
            wrote_reg    <= wrote_next;
            tcnt_reg     <= tcnt_next;
            bus_byte_reg <= bus_byte_next;
            wr_en_reg    <= wr_en_next;
            busy_reg     <= busy_next;
            term_reg     <= term_next;
            done_reg     <= done_next;
            terr_reg     <= terr_next;
        end
    end

    assign bus_byte    = bus_byte_reg;
    assign wr_en       = wr_en_reg;
    assign busy        = busy_reg;
    assign term        = term_reg;
    assign done        = done_reg;
    assign timeout_err = terr_reg;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Testbench for rtc_write_sequencer. Plays the bus-timing engine with random
// phase delays and checks every output on every cycle against a timeline
// model built from the slot list: expected items in a queue, and the edges at
// which wr_en rises / busy drops derived from one cycle per scanned slot.
module tb_rtc_write_sequencer;

    localparam int NF = 9;
    localparam int TO = 16;
    localparam logic [7:0] INIT_V = 8'h00;

    logic        clk = 1'b0;
    logic        reset, start, init_start, abort;
    logic [8:0]  field_mask;
    logic [71:0] field_addr, field_data;
    logic [7:0]  cmd_addr, cmd_data;
    logic        addr_phase, data_phase, step_done;
    logic [7:0]  bus_byte;
    logic        wr_en, busy, term, done, timeout_err;

    always #5 clk = ~clk;

    rtc_write_sequencer #(
        .DATA_W(8), .N_FIELDS(NF), .INIT_VALUE(0), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .init_start(init_start),
        .abort(abort), .field_mask(field_mask), .field_addr(field_addr),
        .field_data(field_data), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .addr_phase(addr_phase), .data_phase(data_phase), .step_done(step_done),
        .bus_byte(bus_byte), .wr_en(wr_en), .busy(busy), .term(term),
        .done(done), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         slot;
    } item_t;

    // model state
    item_t      exp_q[$];
    bit         exp_busy, exp_wr, exp_done, exp_terr;
    logic [7:0] exp_byte;
    int         rise_at, fin_at, hi_run, cyc;

    int n_checks, n_fail;
    int done_cnt, wr_rises, busy_cyc, wr_hi_cyc;
    bit prev_wr;
    bit eng_en;
    int eng_st, eng_wait;

    function automatic void check1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check8(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        exp_busy = 1'b0;
        exp_wr   = 1'b0;
        rise_at  = -1;
        fin_at   = -1;
    endfunction

    // The write list for one run: enabled slots in order, then the command.
    function automatic void build_q(bit init, logic [8:0] m, logic [71:0] fa,
                                    logic [71:0] fd, logic [7:0] ca, logic [7:0] cd);
        item_t it;
        exp_q.delete();
        for (int i = 0; i < NF; i++) begin
            if (init || m[i]) begin
                it.a    = fa[i*8 +: 8];
                it.d    = init ? INIT_V : fd[i*8 +: 8];
                it.slot = i;
                exp_q.push_back(it);
            end
        end
        if (exp_q.size() > 0) begin
            it.a    = ca;
            it.d    = cd;
            it.slot = NF;
            exp_q.push_back(it);
        end
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < NF; i++) begin
            field_addr[i*8 +: 8] = 8'($urandom);
            field_data[i*8 +: 8] = 8'($urandom);
        end
        cmd_addr = 8'($urandom);
        cmd_data = 8'($urandom);
    endtask

    // One clock: advance the model over the edge, compare every output,
    // then let the engine choose its handshake for the next cycle.
    task automatic step();
        logic p_rst, p_start, p_init, p_abort, p_ap, p_dp, p_sd;
        logic [8:0]  p_mask;
        logic [71:0] p_fa, p_fd;
        logic [7:0]  p_ca, p_cd;
        bit sd_eff;
        int p;
        p_rst = reset; p_start = start; p_init = init_start; p_abort = abort;
        p_ap = addr_phase; p_dp = data_phase; p_sd = step_done;
        p_mask = field_mask; p_fa = field_addr; p_fd = field_data;
        p_ca = cmd_addr; p_cd = cmd_data;

        @(posedge clk);
        #1;
        cyc++;

        exp_done = 1'b0;
        if (p_rst) begin
            model_clear();
            exp_byte = 8'h00;
            exp_terr = 1'b0;
        end else if (!exp_busy) begin
            if (p_init || p_start) begin
                exp_terr = 1'b0;
                build_q(p_init, p_mask, p_fa, p_fd, p_ca, p_cd);
                exp_busy = 1'b1;
                hi_run   = 0;
                // one cycle per slot examined, plus the final scan and FINISH
                if (exp_q.size() == 0) fin_at = cyc + NF + 2;
                else                   rise_at = cyc + 1 + exp_q[0].slot;
            end
        end else if (p_abort) begin
            model_clear();
        end else if (exp_wr) begin
            hi_run++;
            sd_eff = p_sd && !p_ap && !p_dp;
            if (hi_run >= TO && !sd_eff) begin
                model_clear();
                exp_terr = 1'b1;
            end else if (p_ap) begin
                exp_byte = exp_q[0].a;
            end else if (p_dp) begin
                exp_byte = exp_q[0].d;
            end else if (p_sd) begin
                p = exp_q[0].slot;
                void'(exp_q.pop_front());
                exp_wr = 1'b0;
                // GAP, then one scan cycle per slot up to the next enabled one
                if (exp_q.size() == 0) fin_at = cyc + 1;
                else                   rise_at = cyc + 1 + exp_q[0].slot - p;
            end
        end else begin
            if (cyc == rise_at) begin
                exp_wr  = 1'b1;
                hi_run  = 0;
                rise_at = -1;
            end
            if (cyc == fin_at) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
                fin_at   = -1;
            end
        end

        check1("busy", busy, exp_busy);
        check1("term", term, !exp_busy);
        check1("wr_en", wr_en, exp_wr);
        check1("done", done, exp_done);
        check1("timeout_err", timeout_err, exp_terr);
        check8("bus_byte", bus_byte, exp_byte);

        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cyc++;
        if (wr_en === 1'b1) wr_hi_cyc++;
        if (wr_en === 1'b1 && !prev_wr) wr_rises++;
        prev_wr = (wr_en === 1'b1);

        addr_phase = 1'b0;
        data_phase = 1'b0;
        step_done  = 1'b0;
        if (wr_en !== 1'b1) begin
            eng_st   = 0;
            eng_wait = $urandom_range(0, 2);
        end else if (eng_en) begin
            if (eng_wait > 0) begin
                eng_wait--;
            end else begin
                case (eng_st)
                    0: begin addr_phase = 1'b1; eng_st = 1; eng_wait = $urandom_range(0, 2); end
                    1: begin data_phase = 1'b1; eng_st = 2; eng_wait = $urandom_range(0, 2); end
                    2: begin step_done = 1'b1; eng_st = 3; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic clear_stats();
        done_cnt = 0; wr_rises = 0; busy_cyc = 0; wr_hi_cyc = 0;
    endtask

    task automatic go(input bit s, input bit i);
        start = s;
        init_start = i;
        step();
        start = 1'b0;
        init_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (busy === 1'b0) ok = 1'b1;
        end
        check1("idle_within_budget", ok, 1'b1);
        if (!ok) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit use_init, use_start, reached;
        int ab_at;

        n_checks = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; init_start = 1'b0; abort = 1'b0;
        addr_phase = 1'b0; data_phase = 1'b0; step_done = 1'b0;
        field_mask = '0; field_addr = '0; field_data = '0;
        cmd_addr = '0; cmd_data = '0;
        eng_en = 1'b1; eng_st = 0; eng_wait = 0; prev_wr = 1'b0;
        model_clear(); exp_byte = 8'h00; exp_terr = 1'b0; hi_run = 0;
        clear_stats();
        rand_fields();

        step(); step();
        reset = 1'b0;
        step();
        check1("rst_busy", busy, 1'b0);
        check1("rst_term", term, 1'b1);
        check1("rst_wr_en", wr_en, 1'b0);
        check8("rst_bus_byte", bus_byte, 8'h00);
        check1("rst_timeout_err", timeout_err, 1'b0);

        // masked write: slots 0 and 2, then the command
        field_mask = 9'b000000101;
        clear_stats();
        go(1'b1, 1'b0);
        check1("mw_busy_first", busy, 1'b1);
        check1("mw_wr_first", wr_en, 1'b0);
        step();
        check1("mw_wr_second", wr_en, 1'b1);
        wait_idle(300);
        check_int("mw_items", wr_rises, 3);
        check_int("mw_done", done_cnt, 1);

        // init: all nine slots with INIT_V, mask ignored
        rand_fields();
        field_mask = 9'($urandom);
        clear_stats();
        go(1'b0, 1'b1);
        wait_idle(400);
        check_int("init_items", wr_rises, 10);
        check_int("init_done", done_cnt, 1);

        // empty mask: busy for N_FIELDS+2 cycles, no write
        field_mask = 9'b0;
        clear_stats();
        go(1'b1, 1'b0);
        wait_idle(100);
        check_int("empty_busy_cycles", busy_cyc, NF + 2);
        check_int("empty_wr_cycles", wr_hi_cyc, 0);
        check_int("empty_done", done_cnt, 1);

        // timeout: engine silent
        eng_en = 1'b0;
        field_mask = 9'b000010000;
        clear_stats();
        go(1'b1, 1'b0);
        wait_idle(200);
        check_int("to_wr_cycles", wr_hi_cyc, 16);
        check1("to_flag", timeout_err, 1'b1);
        check1("to_term", term, 1'b1);
        check_int("to_done", done_cnt, 0);
        eng_en = 1'b1;
        field_mask = 9'b100000000;
        clear_stats();
        go(1'b1, 1'b0);
        check1("to_cleared_by_start", timeout_err, 1'b0);
        wait_idle(200);
        check_int("to_next_done", done_cnt, 1);

        // abort during the second item, then a clean rerun
        field_mask = 9'b000010011;
        clear_stats();
        go(1'b1, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            step();
            if (wr_rises >= 2) reached = 1'b1;
        end
        check1("ab_second_item_seen", reached, 1'b1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check1("ab_busy", busy, 1'b0);
        check1("ab_wr_en", wr_en, 1'b0);
        repeat (3) step();
        check_int("ab_no_done", done_cnt, 0);
        field_mask = 9'b000000001;
        clear_stats();
        go(1'b1, 1'b0);
        step();
        check1("ab_restart_slot0", wr_en, 1'b1);
        wait_idle(200);
        check_int("ab_restart_items", wr_rises, 2);
        check_int("ab_restart_done", done_cnt, 1);

        // start and init_start together, then a start while busy
        rand_fields();
        field_mask = 9'($urandom);
        clear_stats();
        go(1'b1, 1'b1);
        repeat (3) step();
        go(1'b1, 1'b0);
        wait_idle(400);
        check_int("both_items", wr_rises, 10);
        check_int("both_done", done_cnt, 1);

        // reset in the middle of a run
        field_mask = 9'h1FF;
        clear_stats();
        go(1'b1, 1'b0);
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_term", term, 1'b1);
        check1("mid_rst_wr_en", wr_en, 1'b0);
        check8("mid_rst_bus_byte", bus_byte, 8'h00);
        step();

        // random runs, some aborted
        for (int r = 0; r < 30; r++) begin
            rand_fields();
            field_mask = 9'($urandom);
            use_init  = ($urandom_range(0, 3) == 0);
            use_start = use_init ? 1'($urandom_range(0, 1)) : 1'b1;
            ab_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 40)) : -1;
            clear_stats();
            go(use_start, use_init);
            reached = 1'b0;
            for (int i = 0; i < 500 && !reached; i++) begin
                if (i == ab_at) abort = 1'b1;
                step();
                abort = 1'b0;
                if (busy === 1'b0) reached = 1'b1;
            end
            check1("rand_idle_within_budget", reached, 1'b1);
            if (ab_at < 0) check_int("rand_done", done_cnt, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
